// File: rtl/ftf_decoder_29_seq.sv
// Serial FTF (Fibonacci) codeword decoder: one code bit per cycle, MSB first, 29-cycle latency.
// Optional FTF_DEC_CHECK_EN adds a registered code_err (carry out or adjacent-ones check).

// Fallback weights for builds that do not include FNS.vh ahead of this file.
`ifndef FBLEN29
`define FBLEN29 21
`define FNS01 1
`define FNS02 2
`define FNS03 3
`define FNS04 5
`define FNS05 8
`define FNS06 13
`define FNS07 21
`define FNS08 34
`define FNS09 55
`define FNS10 89
`define FNS11 144
`define FNS12 233
`define FNS13 377
`define FNS14 610
`define FNS15 987
`define FNS16 1597
`define FNS17 2584
`define FNS18 4181
`define FNS19 6765
`define FNS20 10946
`define FNS21 17711
`define FNS22 28657
`define FNS23 46368
`define FNS24 75025
`define FNS25 121393
`define FNS26 196418
`define FNS27 317811
`define FNS28 514229
`define FNS29 832040
`endif

module ftf_decoder_29_seq (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [28:0]         code_in,
    input  logic                code_valid,
    output logic                code_ready,
    output logic [`FBLEN29-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                code_err
);

    localparam int W = `FBLEN29;

    typedef logic [W:0] acc_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [28:0] r_shift;
    logic [4:0]  r_idx;
    acc_t        r_acc;
    acc_t        w_weight;
    acc_t        w_acc_next;
    logic        w_bit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (code_valid)      w_state_next = ACC;
            ACC:     if (r_idx == 5'd0)   w_state_next = DONE;
            DONE:    if (data_ready)      w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    always_comb begin
        code_ready = 1'b0;
        data_valid = 1'b0;
        case (r_state)
            IDLE:    code_ready = 1'b1;
            DONE:    data_valid = 1'b1;
            default: ;
        endcase
    end

    // Weight of the bit currently at the head of the shift register.
    always_comb begin
        w_weight = '0;
        case (r_idx)
            5'd0:  w_weight = acc_t'(`FNS01);
            5'd1:  w_weight = acc_t'(`FNS02);
            5'd2:  w_weight = acc_t'(`FNS03);
            5'd3:  w_weight = acc_t'(`FNS04);
            5'd4:  w_weight = acc_t'(`FNS05);
            5'd5:  w_weight = acc_t'(`FNS06);
            5'd6:  w_weight = acc_t'(`FNS07);
            5'd7:  w_weight = acc_t'(`FNS08);
            5'd8:  w_weight = acc_t'(`FNS09);
            5'd9:  w_weight = acc_t'(`FNS10);
            5'd10: w_weight = acc_t'(`FNS11);
            5'd11: w_weight = acc_t'(`FNS12);
            5'd12: w_weight = acc_t'(`FNS13);
            5'd13: w_weight = acc_t'(`FNS14);
            5'd14: w_weight = acc_t'(`FNS15);
            5'd15: w_weight = acc_t'(`FNS16);
            5'd16: w_weight = acc_t'(`FNS17);
            5'd17: w_weight = acc_t'(`FNS18);
            5'd18: w_weight = acc_t'(`FNS19);
            5'd19: w_weight = acc_t'(`FNS20);
            5'd20: w_weight = acc_t'(`FNS21);
            5'd21: w_weight = acc_t'(`FNS22);
            5'd22: w_weight = acc_t'(`FNS23);
            5'd23: w_weight = acc_t'(`FNS24);
            5'd24: w_weight = acc_t'(`FNS25);
            5'd25: w_weight = acc_t'(`FNS26);
            5'd26: w_weight = acc_t'(`FNS27);
            5'd27: w_weight = acc_t'(`FNS28);
            5'd28: w_weight = acc_t'(`FNS29);
            default: w_weight = '0;
        endcase
    end

    assign w_bit      = r_shift[28];
    assign w_acc_next = r_acc + (w_bit ? w_weight : acc_t'(0));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= 5'd28;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: if (code_valid) begin
                    r_shift <= code_in;
                    r_idx   <= 5'd28;
                    r_acc   <= '0;
                end
                ACC: begin
                    r_acc   <= w_acc_next;
                    r_shift <= {r_shift[27:0], 1'b0};
                    if (r_idx != 5'd0) r_idx <= r_idx - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_acc[W-1:0];

`ifdef FTF_DEC_CHECK_EN
    logic r_prev_bit;
    logic r_pair_err;
    logic r_code_err;
    logic w_pair_hit;

    // Odd index i pairs with the previously processed bit i+1.
    assign w_pair_hit = r_idx[0] & w_bit & r_prev_bit;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_bit <= 1'b0;
            r_pair_err <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (code_valid) begin
                    r_prev_bit <= 1'b0;
                    r_pair_err <= 1'b0;
                    r_code_err <= 1'b0;
                end
                ACC: begin
                    r_prev_bit <= w_bit;
                    r_pair_err <= r_pair_err | w_pair_hit;
                    if (r_idx == 5'd0) r_code_err <= w_acc_next[W] | r_pair_err | w_pair_hit;
                end
                default: ;
            endcase
        end
    end

    assign code_err = r_code_err;
`else
    assign code_err = 1'b0;
`endif

endmodule
